// File: rtl/cr_zigzag_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cr_zigzag_serializer
// Description : Captures a quantized 8x8 Cr block in parallel into one of two
//               ping-pong banks and streams its 64 coefficients in JPEG
//               zigzag order with valid/ready flow control. Beat 0 carries
//               the DC DPCM difference; the last non-zero AC zigzag index is
//               reported alongside every beat of the block.
// Revision    : 1.0 - initial release
// ============================================================================
module cr_zigzag_serializer #(
    parameter int DATA_W = 11,
    parameter int OUT_W  = DATA_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [0:7][0:7][DATA_W-1:0] Q,
    output logic                        in_ready,
    input  logic                        frame_start,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W-1:0]     out_data,
    output logic [5:0]                  out_index,
    output logic                        out_last,
    output logic [5:0]                  out_last_nz,
    output logic                        drop_err
);

    // Read FSM encoding
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_STREAM = 1'b1;

    // Zigzag index -> raster position (row*8 + col)
    localparam logic [5:0] c_ZZ_RASTER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Ping-pong storage and per-bank metadata
    logic [0:7][0:7][DATA_W-1:0] r_bank [2];
    logic [5:0]                  r_last_nz [2];
    logic [1:0]                  r_full;
    logic                        r_wr_ptr;
    logic                        r_rd_ptr;

    // Read side state
    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic [5:0]                  r_k;
    logic signed [OUT_W-1:0]     r_prev_dc;
    logic                        r_drop_err;

    // Combinational helpers
    logic                        w_capture;
    logic                        w_hs;
    logic                        w_hs_last;
    logic                        w_other_full;
    logic [5:0]                  w_cap_last_nz;
    logic [0:7][0:7][DATA_W-1:0] w_rd_blk;
    logic [5:0]                  w_raster;
    logic [DATA_W-1:0]           w_coef;
    logic signed [OUT_W-1:0]     w_coef_sext;

    assign in_ready     = ~(r_full[0] & r_full[1]);
    assign w_capture    = in_valid & in_ready;
    assign w_hs         = out_valid & out_ready;
    assign w_hs_last    = w_hs & (r_k == 6'd63);
    // The bank behind the one draining counts as ready if it is being filled now,
    // which is what lets the next block start with no bubble.
    assign w_other_full = r_full[~r_rd_ptr] | (w_capture & (r_wr_ptr != r_rd_ptr));
    assign drop_err     = r_drop_err;

    // Coefficient currently addressed by the beat counter
    assign w_rd_blk    = r_bank[r_rd_ptr];
    assign w_raster    = c_ZZ_RASTER[r_k];
    assign w_coef      = w_rd_blk[w_raster[5:3]][w_raster[2:0]];
    assign w_coef_sext = {{(OUT_W-DATA_W){w_coef[DATA_W-1]}}, w_coef};

    // Last non-zero AC position of the incoming block, in zigzag order
    always_comb begin
        w_cap_last_nz = '0;
        for (int k = 1; k < 64; k++) begin
            if (Q[c_ZZ_RASTER[k][5:3]][c_ZZ_RASTER[k][2:0]] != '0) begin
                w_cap_last_nz = 6'(k);
            end
        end
    end

    // Bank data and last-nz capture; data needs no reset since full flags gate it
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_bank[r_wr_ptr]    <= Q;
            r_last_nz[r_wr_ptr] <= w_cap_last_nz;
        end
    end

    // Bank occupancy and pointers; capture and free of different banks may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_capture) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_hs_last) begin
                r_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= ~r_rd_ptr;
            end
        end
    end

    // Beat counter, DC predictor and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_prev_dc  <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_k <= r_k + 6'd1;
            end
            if (frame_start) begin
                r_prev_dc <= '0;
            end else if (w_hs && (r_k == 6'd0)) begin
                r_prev_dc <= w_coef_sext;
            end
            if (in_valid && !in_ready) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a capture into an empty pipeline starts streaming next cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_full[r_rd_ptr] || w_capture) begin
                    w_state_nxt = c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (w_hs_last && !w_other_full) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM outputs; all derived from registers so they hold during a stall
    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        out_index   = '0;
        out_last    = 1'b0;
        out_last_nz = '0;
        if (r_state == c_ST_STREAM) begin
            out_valid   = 1'b1;
            out_index   = r_k;
            out_last    = (r_k == 6'd63);
            out_last_nz = r_last_nz[r_rd_ptr];
            out_data    = (r_k == 6'd0) ? (w_coef_sext - r_prev_dc) : w_coef_sext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cr_zigzag_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_zigzag_serializer
// Description : Scoreboard bench for cr_zigzag_serializer. Stimulus pushes
//               the expected beats of every captured block; a monitor pops
//               and compares whenever the DUT presents a beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cr_zigzag_serializer;

    localparam int DATA_W = 11;
    localparam int OUT_W  = 12;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        in_valid = 1'b0;
    logic [0:7][0:7][DATA_W-1:0] Q = '0;
    logic                        in_ready;
    logic                        frame_start = 1'b0;
    logic                        out_valid;
    logic                        out_ready = 1'b0;
    logic signed [OUT_W-1:0]     out_data;
    logic [5:0]                  out_index;
    logic                        out_last;
    logic [5:0]                  out_last_nz;
    logic                        drop_err;

    cr_zigzag_serializer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Q(Q), .in_ready(in_ready),
        .frame_start(frame_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_last_nz(out_last_nz), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int index;
        int last;
        int last_nz;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    rmode = 0;       // 0: ready=1, 1: ready=0, 2: toggle, 3: random
    int    model_prev = 0;
    int    blk [8][8];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: walk anti-diagonals to build zigzag order
    task automatic push_model();
        int zr [64];
        int zc [64];
        int n;
        int lnz;
        beat_t b;
        n = 0;
        lnz = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s < 8) ? 0 : s - 7;
            hi = (s < 8) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zr[n] = r; zc[n] = s - r; n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zr[n] = r; zc[n] = s - r; n++; end
            end
        end
        for (int k = 1; k < 64; k++) if (blk[zr[k]][zc[k]] != 0) lnz = k;
        for (int k = 0; k < 64; k++) begin
            b.data    = (k == 0) ? blk[0][0] - model_prev : blk[zr[k]][zc[k]];
            b.index   = k;
            b.last    = (k == 63) ? 1 : 0;
            b.last_nz = lnz;
            exp_q.push_back(b);
        end
        model_prev = blk[0][0];
    endtask

    task automatic send_block(output bit cap);
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                Q[i][j] = DATA_W'(blk[i][j]);
        in_valid = 1'b1;
        cap = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (cap) push_model();
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        model_prev = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d beats_left required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = v;
    endtask

    // Monitor: drives out_ready, compares each presented beat against the queue
    initial begin
        bit    hs63;
        beat_t e;
        int    act;
        hs63 = 1'b0;
        forever begin
            @(negedge clk);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                2: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (rst) begin
                hs63 = 1'b0;
                continue;
            end
            if (hs63 && exp_q.size() > 0) chk("no_bubble", int'(out_valid), 1);
            hs63 = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual index=%0d data=%0d required=no beat",
                             out_index, out_data);
                end else begin
                    e = exp_q[0];
                    act = out_data;
                    checks++;
                    if (act != e.data || int'(out_index) != e.index || int'(out_last) != e.last ||
                        int'(out_last_nz) != e.last_nz) begin
                        errors++;
                        $display("FAIL beat actual data=%0d idx=%0d last=%0d lnz=%0d required data=%0d idx=%0d last=%0d lnz=%0d",
                                 act, out_index, out_last, out_last_nz, e.data, e.index, e.last, e.last_nz);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs63 = (e.last != 0);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit cap;
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_last_nz", int'(out_last_nz), 0);
        chk("rst_drop_err", int'(drop_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Ramp block, full throughput, one-cycle latency
        rmode = 0;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = i * 8 + j;
        send_block(cap);
        chk("ramp_captured", int'(cap), 1);
        chk("ramp_latency_valid", int'(out_valid), 1);
        chk("ramp_latency_index", int'(out_index), 0);
        drain();

        // Back-to-back DC-only blocks
        fill_const(0); blk[0][0] = 100;
        send_block(cap);
        fill_const(0); blk[0][0] = 40;
        send_block(cap);
        chk("b2b_second_captured", int'(cap), 1);
        drain();

        // Overflow: three offers while downstream is stalled
        rmode = 1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = int'($urandom_range(0, 2047)) - 1024;
        send_block(cap);
        chk("ovf_first_captured", int'(cap), 1);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = int'($urandom_range(0, 2047)) - 1024;
        send_block(cap);
        chk("ovf_second_captured", int'(cap), 1);
        chk("ovf_in_ready_low", int'(in_ready), 0);
        fill_const(7);
        send_block(cap);
        chk("ovf_third_dropped", int'(cap), 0);
        chk("ovf_drop_err", int'(drop_err), 1);
        rmode = 0;
        drain();

        // Extreme values with a toggling ready
        pulse_frame_start();
        rmode = 2;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = ((i + j) % 2 == 0) ? 1023 : -1024;
        send_block(cap);
        fill_const(-1024);
        send_block(cap);
        chk("ext_second_captured", int'(cap), 1);
        drain();

        // frame_start between two equal-DC blocks
        rmode = 0;
        pulse_frame_start();
        fill_const(0); blk[0][0] = 500;
        send_block(cap);
        drain();
        pulse_frame_start();
        send_block(cap);
        drain();

        // Random sparse blocks with random backpressure
        rmode = 3;
        for (int n = 0; n < 6; n++) begin
            int dens;
            dens = int'($urandom_range(0, 100));
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    blk[i][j] = (int'($urandom_range(0, 99)) < dens) ? int'($urandom_range(0, 2047)) - 1024 : 0;
            send_block(cap);
            repeat ($urandom_range(0, 70)) @(posedge clk);
        end
        rmode = 0;
        drain();

        // Reset in the middle of a block with the second bank loaded
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = int'($urandom_range(1, 500));
        send_block(cap);
        send_block(cap);
        chk("mid_second_captured", int'(cap), 1);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_index == 6'd20) found = 1'b1;
        end
        chk("mid_reached_beat20", int'(found), 1);
        rst = 1'b1;
        exp_q.delete();
        model_prev = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_drop_err", int'(drop_err), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_stays_idle", int'(out_valid), 0);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) blk[i][j] = i * 8 + j;
        send_block(cap);
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_index", int'(out_index), 0);
        chk("post_rst_dc_diff", int'(out_data), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
